async_fifo_lvl: RTL and testbench

ASYNC_FIFO_LVL -- requirements
Module: async_fifo_lvl

---
 rtl/async_fifo_pkg.sv | 14 +
 rtl/fifo_gray_sync.sv | 19 +
 rtl/async_fifo_lvl.sv | 100 ++++++++++
 tb/tb_async_fifo_lvl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: Gray/binary pointer helpers and legal synchroniser depth range for async_fifo_lvl
package async_fifo_pkg;
  localparam int SYNC_STG_MIN = 2;
  localparam int SYNC_STG_MAX = 4;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/fifo_gray_sync.sv
// fifo_gray_sync: STG-deep flop chain carrying a Gray-coded pointer into another clock domain
module fifo_gray_sync
  import async_fifo_pkg::*;
#(
  parameter int W   = 6,
  parameter int STG = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STG-1:0][W-1:0] sr;
  // shift the pointer along; Gray coding keeps at most one bit changing per source edge
  always_ff @(posedge clk)
    if (rst) sr <= '0;
    else sr <= {sr[STG-2:0], d};
  assign q = sr[STG-1];
endmodule

// File: rtl/async_fifo_lvl.sv
// async_fifo_lvl: dual-clock FIFO with Gray-pointer CDC, per-domain fill levels and sticky error flags.
// Define ASYNC_FIFO_LVL_FWFT_EN for first-word fall-through reads; the default build uses a registered read.
module async_fifo_lvl
  import async_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int SYNC_STG  = 2,
  parameter int AFULL_TH  = 2**ADDR_W - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic              wclk,
  input  logic              rclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic              empty,
  output logic              almost_empty,
  output logic              underflow,
  output logic [ADDR_W:0]   wr_level,
  output logic [ADDR_W:0]   rd_level
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int STG = SYNC_STG < SYNC_STG_MIN ? SYNC_STG_MIN : SYNC_STG > SYNC_STG_MAX ? SYNC_STG_MAX : SYNC_STG;
  localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AE = (ADDR_W+1)'(AEMPTY_TH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0] wbin, wgray, rgray_s, wbin_nxt, wgray_nxt, wr_level_nxt;
  logic [ADDR_W:0] rbin, rgray, wgray_s, rbin_nxt, rgray_nxt, rd_level_nxt;
  logic [STG-1:0] rrst_sr;
  logic rrst, w_inc, r_inc;
  assign w_inc = wr_en && !full;
  assign wbin_nxt = wbin + (ADDR_W+1)'(w_inc);
  assign wgray_nxt = (ADDR_W+1)'(bin2gray(32'(wbin_nxt)));
  assign wr_level_nxt = wbin_nxt - (ADDR_W+1)'(gray2bin(32'(rgray_s)));
  // write domain: pointers, level and flags all advance on the same edge as the write
  always_ff @(posedge wclk)
    if (rst) begin
      wbin <= '0;
      wgray <= '0;
      full <= 1'b0;
      almost_full <= 1'b0;
      overflow <= 1'b0;
      wr_level <= '0;
    end else begin
      wbin <= wbin_nxt;
      wgray <= wgray_nxt;
      full <= wgray_nxt == {~rgray_s[ADDR_W -: 2], rgray_s[ADDR_W-2:0]};
      wr_level <= wr_level_nxt;
      almost_full <= wr_level_nxt >= AF;
      overflow <= overflow || (wr_en && full);
    end
  // storage is deliberately left unreset so it maps onto plain RAM
  always_ff @(posedge wclk)
    if (w_inc) mem[wbin[ADDR_W-1:0]] <= wr_data;
  // read-domain reset asserts as soon as rst rises and releases cleanly on rclk
  always_ff @(posedge rclk or posedge rst)
    if (rst) rrst_sr <= '1;
    else rrst_sr <= {rrst_sr[STG-2:0], 1'b0};
  assign rrst = rrst_sr[STG-1];
  fifo_gray_sync #(.W(ADDR_W+1), .STG(STG)) u_w2r (.clk(rclk), .rst(rrst), .d(wgray), .q(wgray_s));
  fifo_gray_sync #(.W(ADDR_W+1), .STG(STG)) u_r2w (.clk(wclk), .rst(rst), .d(rgray), .q(rgray_s));
  assign r_inc = rd_en && !empty;
  assign rbin_nxt = rbin + (ADDR_W+1)'(r_inc);
  assign rgray_nxt = (ADDR_W+1)'(bin2gray(32'(rbin_nxt)));
  assign rd_level_nxt = (ADDR_W+1)'(gray2bin(32'(wgray_s))) - rbin_nxt;
  // read domain: flags judged against the lagging write pointer, so they are only ever pessimistic
  always_ff @(posedge rclk)
    if (rrst) begin
      rbin <= '0;
      rgray <= '0;
      empty <= 1'b1;
      almost_empty <= 1'b1;
      underflow <= 1'b0;
      rd_level <= '0;
    end else begin
      rbin <= rbin_nxt;
      rgray <= rgray_nxt;
      empty <= rgray_nxt == wgray_s;
      rd_level <= rd_level_nxt;
      almost_empty <= rd_level_nxt <= AE;
      underflow <= underflow || (rd_en && empty);
    end
`ifdef ASYNC_FIFO_LVL_FWFT_EN
  // keep the head word on rd_data so it is already valid whenever empty is low
  always_ff @(posedge rclk)
    if (rrst) rd_data <= '0;
    else rd_data <= mem[rbin_nxt[ADDR_W-1:0]];
`else
  // registered read: the popped word appears on the edge after the pop
  always_ff @(posedge rclk)
    if (rrst) rd_data <= '0;
    else if (r_inc) rd_data <= mem[rbin[ADDR_W-1:0]];
`endif
endmodule

// File: tb/tb_async_fifo_lvl.sv
`timescale 1ns/100ps
// tb_async_fifo_lvl: directed and randomized checks of async_fifo_lvl against a queue model
module tb_async_fifo_lvl;
  localparam int DW = 8, AW = 5, STG = 2, NWORDS = 10000;
  logic wclk = 0, rclk = 0, rst = 1, wr_en = 0, rd_en = 0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic full, almost_full, overflow, empty, almost_empty, underflow;
  logic [AW:0] wr_level, rd_level;
  int n_chk = 0, n_err = 0, nwr = 0, nrd = 0, n = 0;
  logic [DW-1:0] sb [$];

  always #5 wclk = ~wclk;
  always #13.5 rclk = ~rclk;

  async_fifo_lvl dut (
    .wclk(wclk), .rclk(rclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .full(full), .almost_full(almost_full),
    .overflow(overflow), .empty(empty), .almost_empty(almost_empty),
    .underflow(underflow), .wr_level(wr_level), .rd_level(rd_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    @(negedge wclk);
    wr_data = d;
    wr_en = 1;
    @(negedge wclk);
    wr_en = 0;
  endtask

  task automatic pop(input logic [DW-1:0] exp);
    int k = 0;
    @(negedge rclk);
    while (empty && k < 20) begin
      @(negedge rclk);
      k++;
    end
    chk("pop_avail", 32'(empty), 0);
`ifdef ASYNC_FIFO_LVL_FWFT_EN
    chk("pop_head", 32'(rd_data), 32'(exp));
`endif
    rd_en = 1;
    @(negedge rclk);
    rd_en = 0;
`ifndef ASYNC_FIFO_LVL_FWFT_EN
    chk("pop_data", 32'(rd_data), 32'(exp));
`endif
  endtask

  initial begin
    repeat (20) @(negedge wclk);
    rst = 0;
    repeat (8) @(negedge rclk);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_wr_level", 32'(wr_level), 0);
    chk("rst_rd_level", 32'(rd_level), 0);
`ifndef ASYNC_FIFO_LVL_FWFT_EN
    chk("rst_rd_data", 32'(rd_data), 0);
`endif
    // fill to full with 0x00..0x1F
    @(negedge wclk);
    for (int i = 0; i < 32; i++) begin
      wr_en = 1;
      wr_data = 8'(i);
      @(negedge wclk);
      chk("fill_level", 32'(wr_level), i + 1);
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 28));
      chk("fill_full", 32'(full), 32'(i == 31));
    end
    wr_data = 8'hAA;
    @(negedge wclk);
    wr_en = 0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_level", 32'(wr_level), 32);
    repeat (6) @(negedge rclk);
    chk("full_rd_level", 32'(rd_level), 32);
    chk("full_aempty", 32'(almost_empty), 0);
    for (int i = 0; i < 32; i++) pop(8'(i));
    chk("drain_empty", 32'(empty), 1);
    chk("drain_no_udf", 32'(underflow), 0);
    @(negedge rclk);
    rd_en = 1;
    @(negedge rclk);
    rd_en = 0;
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_rd_level", 32'(rd_level), 0);
`ifndef ASYNC_FIFO_LVL_FWFT_EN
    chk("udf_rd_data", 32'(rd_data), 32'h1F);
`endif
    // first word into an empty FIFO
    @(negedge wclk);
    wr_data = 8'h40;
    wr_en = 1;
    @(posedge wclk);
    #1 wr_en = 0;
    n = 0;
    while (empty && n < 10) begin
      @(posedge rclk);
      #1 n++;
    end
    chk("empty_latency", 32'(n >= 2 && n <= STG + 1), 1);
    chk("aempty_one", 32'(almost_empty), 1);
    for (int k = 2; k <= 6; k++) begin
      push(8'(8'h40 + k - 1));
      repeat (6) @(negedge rclk);
      chk("ae_level", 32'(rd_level), k);
      chk("ae_flag", 32'(almost_empty), 32'(k <= 4));
    end
    for (int k = 0; k < 6; k++) pop(8'(8'h40 + k));
    chk("ae_drained", 32'(empty), 1);
    // reset mid-operation discards contents and clears sticky flags
    for (int i = 0; i < 20; i++) push(8'(8'h80 + i));
    @(negedge wclk);
    rst = 1;
    repeat (30) @(negedge wclk);
    rst = 0;
    repeat (8) @(negedge rclk);
    chk("mrst_empty", 32'(empty), 1);
    chk("mrst_wr_level", 32'(wr_level), 0);
    chk("mrst_rd_level", 32'(rd_level), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    chk("mrst_udf", 32'(underflow), 0);
`ifndef ASYNC_FIFO_LVL_FWFT_EN
    chk("mrst_rd_data", 32'(rd_data), 0);
`endif
    push(8'h77);
    pop(8'h77);
    repeat (6) @(negedge rclk);
    chk("mrst_after", 32'(empty), 1);
    // random concurrent traffic against the queue model
    fork
      begin
        for (int c = 0; c < 50000 && nwr < NWORDS; c++) begin
          @(negedge wclk);
          wr_en = $urandom_range(99) < (((c / 400) % 2 == 1) ? 60 : 30);
          wr_data = 8'($urandom);
          if (wr_en && !full) begin
            sb.push_back(wr_data);
            nwr++;
          end
        end
        @(negedge wclk);
        wr_en = 0;
      end
      begin
        logic [31:0] exp = '0;
        bit pend = 0;
        for (int c = 0; c < 20000 && (nrd < NWORDS || pend); c++) begin
          @(negedge rclk);
`ifdef ASYNC_FIFO_LVL_FWFT_EN
          if (!empty) chk("rand_head", 32'(rd_data), sb.size() > 0 ? 32'(sb[0]) : 32'hFFFF_FFFF);
`else
          if (pend) chk("rand_data", 32'(rd_data), exp);
          pend = 0;
`endif
          chk("full_and_empty", 32'(full && empty), 0);
          rd_en = ($urandom_range(15) != 0) && (nrd < NWORDS);
          if (rd_en && !empty) begin
            exp = sb.size() > 0 ? 32'(sb.pop_front()) : 32'hFFFF_FFFF;
            pend = 1;
            nrd++;
          end
        end
        rd_en = 0;
      end
    join
    repeat (10) @(negedge rclk);
    chk("rand_written", nwr, NWORDS);
    chk("rand_read", nrd, NWORDS);
    chk("rand_sb_left", sb.size(), 0);
    chk("rand_final_empty", 32'(empty), 1);
    chk("rand_final_wr_level", 32'(wr_level), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
